// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the CPU's HI/LO multiply/divide unit.
package mips_cpu_pkg;

  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} hilo_op_t;

  typedef enum logic [1:0] {IDLE, ITER, FIXUP} state_t;

  localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;

  function automatic logic is_signed_op(input hilo_op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic is_div_op(input hilo_op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One radix-2 iteration: MSB-first shift-add multiply or restoring divide.
// The accumulator holds {remainder, quotient} for divides.
module mips_cpu_muldiv_step
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  input  hilo_op_t           mode,
  input  logic               next_bit,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    rem_sh  = {acc_in[2*WIDTH-1:WIDTH], next_bit};
    // The true difference always fits in WIDTH bits whenever the subtract is taken.
    diff    = rem_sh[WIDTH-1:0] - operand;
    acc_out = {acc_in[2*WIDTH-2:0], 1'b0} + (next_bit ? {{WIDTH{1'b0}}, operand} : '0);
    if (is_div_op(mode)) begin
      if (rem_sh >= {1'b0, operand})
        acc_out = {diff, acc_in[WIDTH-2:0], 1'b1};
      else
        acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_cpu_hilo_muldiv_ctrl.sv
// HI/LO owner and iterative MULT/MULTU/DIV/DIVU sequencer for the execute stage.
// Operates on magnitudes and applies sign correction in a final FIXUP cycle.
module mips_cpu_hilo_muldiv_ctrl
  import mips_cpu_pkg::hilo_op_t;
  import mips_cpu_pkg::state_t;
  import mips_cpu_pkg::IDLE;
  import mips_cpu_pkg::FIXUP;
  import mips_cpu_pkg::DIVZERO_LO;
  import mips_cpu_pkg::is_signed_op;
  import mips_cpu_pkg::is_div_op;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             hilo_read,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  localparam int CW = $clog2(ITER);

  state_t             state;
  hilo_op_t           op_q;
  logic [CW-1:0]      counter;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   src_q;
  logic [WIDTH-1:0]   operand_q;
  logic [WIDTH-1:0]   rs_raw_q;
  logic               neg_q;
  logic               rem_neg_q;
  logic               div_zero_q;

  logic               signed_op;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy  = (state != IDLE);
  assign stall = busy & (start | mthi | mtlo | hilo_read);

  always_comb begin
    signed_op = is_signed_op(hilo_op_t'(op));
    rs_neg    = signed_op & rs_val[WIDTH-1];
    rt_neg    = signed_op & rt_val[WIDTH-1];
    rs_mag    = rs_neg ? -rs_val : rs_val;
    rt_mag    = rt_neg ? -rt_val : rt_val;
    prod_fix  = neg_q ? -acc : acc;
    quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = rem_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_in   (acc),
    .operand  (operand_q),
    .mode     (op_q),
    .next_bit (src_q[WIDTH-1]),
    .acc_out  (acc_next)
  );

  // The ITER state label is package-qualified because the ITER parameter shadows it here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      op_q       <= hilo_op_t'(2'b00);
      counter    <= '0;
      acc        <= '0;
      src_q      <= '0;
      operand_q  <= '0;
      rs_raw_q   <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else if (clk_enable) begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q       <= hilo_op_t'(op);
            src_q      <= rs_mag;
            operand_q  <= rt_mag;
            rs_raw_q   <= rs_val;
            neg_q      <= rs_neg ^ rt_neg;
            rem_neg_q  <= rs_neg;
            div_zero_q <= (rt_val == '0);
            acc        <= '0;
            counter    <= '0;
            state      <= mips_cpu_pkg::ITER;
          end else begin
            if (mthi) hi <= rs_val;
            if (mtlo) lo <= rs_val;
          end
        end
        mips_cpu_pkg::ITER: begin
          acc     <= acc_next;
          src_q   <= {src_q[WIDTH-2:0], 1'b0};
          counter <= counter + 1'b1;
          if (counter == CW'(ITER - 1)) state <= FIXUP;
        end
        FIXUP: begin
          if (is_div_op(op_q)) begin
            if (div_zero_q) begin
              lo <= DIVZERO_LO;
              hi <= rs_raw_q;
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
